// File: rtl/icache_pkg.sv
// Shared widths, constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int REG_W  = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } icache_state_e;

    function automatic int tag_width(input int addr_w, input int index_bits, input int word_sel_bits);
        return addr_w - index_bits - word_sel_bits - 2;
    endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays: one combinational read port, word write, tag/valid write, clear-all.
module icache_store
    import icache_pkg::*;
#(
    parameter int INDEX_BITS    = 6,
    parameter int WORD_SEL_BITS = 2,
    parameter int TAG_W         = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_BITS-1:0]    rd_index,
    input  logic [WORD_SEL_BITS-1:0] rd_word,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [INST_W-1:0]        rd_data,
    input  logic                     word_we,
    input  logic [INDEX_BITS-1:0]    wr_index,
    input  logic [WORD_SEL_BITS-1:0] wr_word,
    input  logic [INST_W-1:0]        wr_data,
    input  logic                     line_we,
    input  logic                     line_valid,
    input  logic [TAG_W-1:0]         line_tag,
    input  logic                     clear
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << WORD_SEL_BITS;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [INST_W-1:0] data [LINES][WORDS];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index][rd_word];

    // A line write in the same cycle as a clear wins for that line; the caller folds
    // the invalidate into line_valid so the net effect stays "invalid".
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (clear)
                valid <= '0;
            if (line_we)
                valid[wr_index] <= line_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we)
            tags[wr_index] <= line_tag;
        if (word_we)
            data[wr_index][wr_word] <= wr_data;
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-latency hit, 4-word in-order refill on miss.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS    = 6,
    parameter int WORD_SEL_BITS = 2,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              inv_i,
    output logic [INST_W-1:0] inst_o,
    output logic              stallreq,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_ce_o,
    input  logic [INST_W-1:0] mem_data_i,
    input  logic              mem_data_ready
);
    localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS, WORD_SEL_BITS);

    icache_state_e            state;
    logic [TAG_W-1:0]         miss_tag;
    logic [INDEX_BITS-1:0]    miss_index;
    logic [WORD_SEL_BITS-1:0] cnt;
    logic                     inv_pending;

    logic [TAG_W-1:0]         pc_tag;
    logic [INDEX_BITS-1:0]    pc_index;
    logic [WORD_SEL_BITS-1:0] pc_word;
    logic                     unused_pc_lsb;

    assign pc_tag        = pc_i[ADDR_W-1 -: TAG_W];
    assign pc_index      = pc_i[WORD_SEL_BITS+2 +: INDEX_BITS];
    assign pc_word       = pc_i[2 +: WORD_SEL_BITS];
    assign unused_pc_lsb = ^pc_i[1:0];

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [INST_W-1:0] rd_data;
    logic              hit, miss, word_we, line_we;

    assign hit     = ce_i && rd_valid && (rd_tag == pc_tag);
    assign miss    = ce_i && !hit;
    assign word_we = !rst && (state == ST_REFILL) && mem_data_ready;
    assign line_we = word_we && (cnt == '1);

    icache_store #(
        .INDEX_BITS   (INDEX_BITS),
        .WORD_SEL_BITS(WORD_SEL_BITS),
        .TAG_W        (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (pc_index),
        .rd_word   (pc_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .word_we   (word_we),
        .wr_index  (miss_index),
        .wr_word   (cnt),
        .wr_data   (mem_data_i),
        .line_we   (line_we),
        .line_valid(!(inv_pending || inv_i)),
        .line_tag  (miss_tag),
        .clear     (inv_i && !rst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            inv_pending <= 1'b0;
            miss_tag    <= '0;
            miss_index  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    inv_pending <= 1'b0;
                    if (miss) begin
                        miss_tag   <= pc_tag;
                        miss_index <= pc_index;
                        cnt        <= '0;
                        state      <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (inv_i)
                        inv_pending <= 1'b1;
                    if (mem_data_ready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '1)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    inv_pending <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state; rst forces them quiet within the same cycle.
    assign mem_ce_o   = !rst && (state == ST_REFILL);
    assign mem_addr_o = mem_ce_o ? {miss_tag, miss_index, cnt, 2'b00} : '0;
    assign stallreq   = !rst && ((state == ST_IDLE) ? miss : 1'b1);
    assign inst_o     = (!rst && (state == ST_IDLE) && hit) ? rd_data : ZERO_WORD;

endmodule
